// File: rtl/qam_symbol_streamer.sv
// Host-to-modulator streamer: packs addressed Rx packet bytes into words, buffers them in a FIFO,
// and emits QAM symbols at a programmable period. Sends XOFF/XON packets to the host with hysteresis.
module qam_symbol_streamer #(
    parameter int unsigned WordW     = 16,
    parameter int unsigned SymW      = 4,
    parameter int unsigned Depth     = 4096,
    parameter logic [7:0]  AddrId    = 8'h10,
    parameter logic [7:0]  HostId    = 8'hAA,
    parameter int unsigned AfullLvl  = Depth - 64,
    parameter int unsigned AemptyLvl = 64,
    parameter int unsigned PeriodW   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_valid_i,
    input  logic                      rx_sop_i,
    input  logic                      rx_eop_i,
    input  logic [7:0]                rx_dest_i,
    input  logic [7:0]                rx_data_i,
    input  logic [PeriodW-1:0]        sym_period_i,
    input  logic                      enable_i,
    output logic [$clog2(Depth):0]    fifo_count_o,
    output logic [SymW-1:0]           sym_o,
    output logic                      sym_valid_o,
    output logic                      underrun_o,
    output logic                      overflow_o,
    output logic                      tx_valid_o,
    output logic                      tx_sop_o,
    output logic                      tx_eop_o,
    output logic [7:0]                tx_length_o,
    output logic [7:0]                tx_source_o,
    output logic [7:0]                tx_dest_o,
    output logic [7:0]                tx_data_o,
    input  logic                      tx_ready_i
);
    localparam int unsigned Bytes    = WordW / 8;
    localparam int unsigned ByteIdxW = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam int unsigned Syms     = WordW / SymW;
    localparam int unsigned SymIdxW  = $clog2(Syms + 1);
    localparam int unsigned AddrW    = $clog2(Depth);
    localparam int unsigned CntW     = AddrW + 1;

    typedef enum logic {RxWait, RxData} rx_state_e;
    typedef enum logic {FcIdle, FcSend} fc_state_e;

    rx_state_e            rx_state_q, rx_state_d;
    logic [ByteIdxW-1:0]  byte_idx_q, byte_idx_d, idx;
    logic [WordW-1:0]     acc_q, acc_d, word_new;
    logic                 wr_pend_q, wr_pend_d;
    logic [WordW-1:0]     wr_word_q, wr_word_d;

    logic [WordW-1:0]     mem_q [Depth];
    logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 overflow_q;
    logic                 full, empty, push_ok, pop;

    logic [PeriodW-1:0]   cnt_q, cnt_d, period_eff;
    logic                 tick;
    logic [WordW-1:0]     shreg_q, shreg_d, head;
    logic [SymIdxW-1:0]   left_q, left_d;
    logic [SymW-1:0]      sym_q, sym_d;
    logic                 sym_valid_q, sym_valid_d, underrun_q, underrun_d;

    fc_state_e            fc_state_q, fc_state_d;
    logic                 throttled_q, throttled_d, hdr_q, hdr_d;
    logic [7:0]           tx_data_q, tx_data_d;

    // Rx reassembly: byte 0 of a word lands in [7:0]; completed words are pushed one cycle later.
    always_comb begin
        rx_state_d = rx_state_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        wr_pend_d  = 1'b0;
        wr_word_d  = wr_word_q;
        idx        = (rx_state_q == RxWait) ? '0 : byte_idx_q;
        word_new   = acc_q;
        word_new[idx*8 +: 8] = rx_data_i;
        if (rx_valid_i && (rx_state_q == RxData ||
                           (rx_sop_i && rx_dest_i == AddrId))) begin
            rx_state_d = rx_eop_i ? RxWait : RxData;
            if (idx == ByteIdxW'(Bytes - 1)) begin
                wr_pend_d  = 1'b1;
                wr_word_d  = word_new;
                byte_idx_d = '0;
            end else begin
                acc_d      = word_new;
                byte_idx_d = idx + 1'b1;
            end
            if (rx_eop_i) byte_idx_d = '0;
        end
    end

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign push_ok = wr_pend_q && !full;
    assign head    = mem_q[rd_ptr_q];

    assign period_eff = (sym_period_i < PeriodW'(2)) ? PeriodW'(2) : sym_period_i;
    // >= rather than == so a shortened period ticks on the next cycle.
    assign tick       = enable_i && (cnt_q >= period_eff - PeriodW'(1));
    assign cnt_d      = !enable_i ? cnt_q : (tick ? '0 : cnt_q + PeriodW'(1));
    assign pop        = tick && (left_q == '0) && !empty;
    assign count_d    = count_q + CntW'(push_ok) - CntW'(pop);

    always_comb begin
        sym_d       = sym_q;
        shreg_d     = shreg_q;
        left_d      = left_q;
        sym_valid_d = 1'b0;
        underrun_d  = 1'b0;
        if (tick) begin
            if (left_q != '0) begin
                sym_d       = shreg_q[SymW-1:0];
                shreg_d     = shreg_q >> SymW;
                left_d      = left_q - 1'b1;
                sym_valid_d = 1'b1;
            end else if (!empty) begin
                sym_d       = head[SymW-1:0];
                shreg_d     = head >> SymW;
                left_d      = SymIdxW'(Syms - 1);
                sym_valid_d = 1'b1;
            end else begin
                underrun_d  = 1'b1;
            end
        end
    end

    always_comb begin
        fc_state_d  = fc_state_q;
        throttled_d = throttled_q;
        tx_data_d   = tx_data_q;
        hdr_d       = hdr_q;
        tx_valid_o  = 1'b0;
        unique case (fc_state_q)
            FcIdle: begin
                if (count_q >= CntW'(AfullLvl) && !throttled_q) begin
                    fc_state_d = FcSend;
                    tx_data_d  = 8'hFF;
                    hdr_d      = 1'b1;
                end else if (count_q <= CntW'(AemptyLvl) && throttled_q) begin
                    fc_state_d = FcSend;
                    tx_data_d  = 8'h00;
                    hdr_d      = 1'b1;
                end
            end
            FcSend: begin
                if (tx_ready_i) begin
                    tx_valid_o  = 1'b1;
                    throttled_d = (tx_data_q == 8'hFF);
                    fc_state_d  = FcIdle;
                end
            end
            default: fc_state_d = FcIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_word_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q  <= RxWait;
            byte_idx_q  <= '0;
            acc_q       <= '0;
            wr_pend_q   <= 1'b0;
            wr_word_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            left_q      <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            fc_state_q  <= FcIdle;
            throttled_q <= 1'b0;
            hdr_q       <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            byte_idx_q  <= byte_idx_d;
            acc_q       <= acc_d;
            wr_pend_q   <= wr_pend_d;
            wr_word_q   <= wr_word_d;
            wr_ptr_q    <= wr_ptr_q + AddrW'(push_ok);
            rd_ptr_q    <= rd_ptr_q + AddrW'(pop);
            count_q     <= count_d;
            overflow_q  <= overflow_q | (wr_pend_q & full);
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            left_q      <= left_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            underrun_q  <= underrun_d;
            fc_state_q  <= fc_state_d;
            throttled_q <= throttled_d;
            hdr_q       <= hdr_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign fifo_count_o = count_q;
    assign sym_o        = sym_q;
    assign sym_valid_o  = sym_valid_q;
    assign underrun_o   = underrun_q;
    assign overflow_o   = overflow_q;
    // Header fields are constant once the first packet has been prepared.
    assign tx_sop_o     = hdr_q;
    assign tx_eop_o     = hdr_q;
    assign tx_length_o  = hdr_q ? 8'd1 : 8'd0;
    assign tx_source_o  = hdr_q ? AddrId : 8'h00;
    assign tx_dest_o    = hdr_q ? HostId : 8'h00;
    assign tx_data_o    = tx_data_q;

endmodule

// File: tb/tb_qam_symbol_streamer.sv
// Directed bench for qam_symbol_streamer with a 16-word FIFO (XOFF at 12, XON at 4).
module tb_qam_symbol_streamer;
    localparam int unsigned Depth = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
    logic [7:0]  rx_dest = 8'h00, rx_data = 8'h00;
    logic [31:0] period = 32'd4;
    logic        en = 1'b0;
    logic        tx_ready = 1'b0;
    logic [4:0]  count;
    logic [3:0]  sym;
    logic        sym_valid, underrun, overflow;
    logic        tx_valid, tx_sop, tx_eop;
    logic [7:0]  tx_length, tx_source, tx_dest, tx_data;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [3:0]  syms[$];
    int          stamps[$];
    int          under_cnt = 0;
    int          tx_cnt = 0;
    logic [7:0]  last_tx = 8'h00;

    qam_symbol_streamer #(
        .WordW(16), .SymW(4), .Depth(Depth), .AddrId(8'h10), .HostId(8'hAA),
        .AfullLvl(12), .AemptyLvl(4), .PeriodW(32)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_sop_i(rx_sop), .rx_eop_i(rx_eop),
        .rx_dest_i(rx_dest), .rx_data_i(rx_data), .sym_period_i(period), .enable_i(en),
        .fifo_count_o(count), .sym_o(sym), .sym_valid_o(sym_valid), .underrun_o(underrun),
        .overflow_o(overflow), .tx_valid_o(tx_valid), .tx_sop_o(tx_sop), .tx_eop_o(tx_eop),
        .tx_length_o(tx_length), .tx_source_o(tx_source), .tx_dest_o(tx_dest),
        .tx_data_o(tx_data), .tx_ready_i(tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid) begin
                syms.push_back(sym);
                stamps.push_back(cyc);
            end
            if (underrun) under_cnt <= under_cnt + 1;
            if (tx_valid) begin
                tx_cnt  <= tx_cnt + 1;
                last_tx <= tx_data;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic sop, input logic eop, input logic [7:0] dest,
                             input logic [7:0] data);
        rx_valid = 1'b1; rx_sop = sop; rx_eop = eop; rx_dest = dest; rx_data = data;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    // One packet of n words: low byte = index, high byte = hi.
    task automatic send_words(input int n, input logic [7:0] hi);
        for (int i = 0; i < n; i++) begin
            send_byte(i == 0, 1'b0, 8'h10, 8'(i));
            send_byte(1'b0, i == n - 1, 8'h10, hi);
        end
    endtask

    task automatic run_en(input int n);
        en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic check_syms(input string tag, input int base, input logic [3:0] exp[8]);
        check({tag, "_nsym"}, 32'(syms.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < syms.size(); k++)
            check($sformatf("%s_sym%0d", tag, k), 32'(syms[base+k]), 32'(exp[k]));
    endtask

    initial begin
        int          base, ub, bad;
        logic [15:0] w;
        logic [3:0]  e1 [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
        logic [3:0]  e5 [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

        idle(3);
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_symvalid", 32'(sym_valid), 32'd0);
        check("rst_txdest", 32'(tx_dest), 32'd0);

        // 1: two words, period 4, then one underrun
        send_byte(1'b1, 1'b0, 8'h10, 8'h34);
        send_byte(1'b0, 1'b0, 8'h10, 8'h12);
        send_byte(1'b0, 1'b0, 8'h10, 8'h78);
        send_byte(1'b0, 1'b1, 8'h10, 8'h56);
        idle(3);
        check("t1_count", 32'(count), 32'd2);
        base = syms.size(); ub = under_cnt;
        run_en(36);
        idle(2);
        check_syms("t1", base, e1);
        bad = 0;
        for (int k = 1; k < 8 && base + k < syms.size(); k++)
            if (stamps[base+k] - stamps[base+k-1] != 4) bad++;
        check("t1_spacing", 32'(bad), 32'd0);
        check("t1_underrun", 32'(under_cnt - ub), 32'd1);

        // 2: foreign address ignored; 3-byte packet keeps one word
        send_byte(1'b1, 1'b0, 8'h11, 8'h01);
        send_byte(1'b0, 1'b0, 8'h11, 8'h02);
        send_byte(1'b0, 1'b0, 8'h11, 8'h03);
        send_byte(1'b0, 1'b1, 8'h11, 8'h04);
        idle(3);
        check("t2_foreign", 32'(count), 32'd0);
        send_byte(1'b1, 1'b0, 8'h10, 8'hAB);
        send_byte(1'b0, 1'b0, 8'h10, 8'hCD);
        send_byte(1'b0, 1'b1, 8'h10, 8'hEF);
        idle(3);
        check("t2_partial", 32'(count), 32'd1);
        base = syms.size(); ub = under_cnt;
        run_en(16);
        idle(2);
        check("t2_nsym", 32'(syms.size() - base), 32'd4);
        w = 16'h0;
        for (int k = 0; k < 4 && base + k < syms.size(); k++) w[k*4 +: 4] = syms[base+k];
        check("t2_word", 32'(w), 32'hCDAB);
        check("t2_underrun", 32'(under_cnt - ub), 32'd0);

        // 3: XOFF at 12, XON at 4, nothing in between
        period = 32'd2;
        base = tx_cnt;
        send_words(12, 8'h30);
        idle(3);
        check("t3_count", 32'(count), 32'd12);
        check("t3_noready", 32'(tx_valid), 32'd0);
        tx_ready = 1'b1;
        #1;
        check("t3_txvalid", 32'(tx_valid), 32'd1);
        check("t3_xoff", 32'(tx_data), 32'hFF);
        check("t3_hdr", {tx_sop, tx_eop, 6'd0, tx_length, tx_source, tx_dest}, 32'hC00110AA);
        idle(1);
        run_en(32);
        idle(2);
        check("t3_mid_count", 32'(count), 32'd8);
        check("t3_mid_pkts", 32'(tx_cnt - base), 32'd1);
        run_en(32);
        idle(3);
        check("t3_xon_pkts", 32'(tx_cnt - base), 32'd2);
        check("t3_xon", 32'(last_tx), 32'h00);
        run_en(32);
        send_words(8, 8'h31);
        idle(2);
        run_en(64);
        idle(3);
        check("t3_norepeat", 32'(tx_cnt - base), 32'd2);
        check("t3_empty", 32'(count), 32'd0);

        // 4: DEPTH+1 words with timer frozen
        send_words(Depth + 1, 8'hA0);
        idle(3);
        check("t4_count", 32'(count), 32'(Depth));
        check("t4_overflow", 32'(overflow), 32'd1);
        base = syms.size(); ub = under_cnt;
        run_en(128);
        idle(2);
        check("t4_nsym", 32'(syms.size() - base), 32'd64);
        w = 16'h0;
        for (int k = 0; k < 4 && base + 60 + k < syms.size(); k++) w[k*4 +: 4] = syms[base+60+k];
        check("t4_lastword", 32'(w), 32'hA00F);
        check("t4_underrun", 32'(under_cnt - ub), 32'd0);
        check("t4_sticky", 32'(overflow), 32'd1);

        // 5: period 8 -> 2 with count past the new limit, enable gap
        send_byte(1'b1, 1'b0, 8'h10, 8'h21);
        send_byte(1'b0, 1'b0, 8'h10, 8'h43);
        send_byte(1'b0, 1'b0, 8'h10, 8'h65);
        send_byte(1'b0, 1'b1, 8'h10, 8'h87);
        idle(3);
        base = syms.size(); ub = under_cnt;
        period = 32'd8;
        run_en(13);
        period = 32'd2;
        run_en(5);
        idle(10);
        run_en(8);
        idle(2);
        check_syms("t5", base, e5);
        check("t5_underrun", 32'(under_cnt - ub), 32'd0);

        // 6: reset mid-word and mid-packet
        send_byte(1'b1, 1'b0, 8'h10, 8'hC3);
        send_byte(1'b0, 1'b1, 8'h10, 8'h00);
        idle(3);
        run_en(4);
        send_byte(1'b1, 1'b0, 8'h10, 8'h55);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_sym", 32'(sym), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_tx", {tx_valid, tx_sop, tx_eop, 5'd0, tx_length, tx_source, tx_dest},
              32'h0);
        check("t6_txdata", 32'(tx_data), 32'd0);
        send_byte(1'b0, 1'b0, 8'h10, 8'h01);
        send_byte(1'b0, 1'b0, 8'h10, 8'h02);
        send_byte(1'b0, 1'b0, 8'h10, 8'h03);
        send_byte(1'b0, 1'b1, 8'h10, 8'h04);
        idle(3);
        check("t6_nosop", 32'(count), 32'd0);
        send_byte(1'b1, 1'b0, 8'h10, 8'h9A);
        send_byte(1'b0, 1'b1, 8'h10, 8'hBC);
        idle(3);
        check("t6_recover", 32'(count), 32'd1);
        base = syms.size(); ub = under_cnt;
        run_en(8);
        idle(2);
        check("t6_nsym", 32'(syms.size() - base), 32'd4);
        w = 16'h0;
        for (int k = 0; k < 4 && base + k < syms.size(); k++) w[k*4 +: 4] = syms[base+k];
        check("t6_word", 32'(w), 32'hBC9A);
        check("t6_underrun", 32'(under_cnt - ub), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
